// File: rtl/seq_div_if.sv
// Handshake/operand bundle for the sequential signed divider.
// The dz flag is only carried when SEQ_DIV_DZ_EN is defined.
interface seq_div_if #(
   parameter int WIDTH = 8
);
   logic                    start;
   logic signed [WIDTH-1:0] x;
   logic signed [WIDTH-1:0] y;
   logic signed [WIDTH-1:0] q;
   logic signed [WIDTH-1:0] r;
   logic                    busy;
   logic                    valid;
`ifdef SEQ_DIV_DZ_EN
   logic                    dz;
`endif

   modport master (
      output start, x, y,
      input  q, r, busy, valid
`ifdef SEQ_DIV_DZ_EN
      , input dz
`endif
   );

   modport slave (
      input  start, x, y,
      output q, r, busy, valid
`ifdef SEQ_DIV_DZ_EN
      , output dz
`endif
   );
endinterface

// File: rtl/seq_div.sv
// Sequential signed restoring divider, one quotient bit per cycle, truncating toward zero.
// Optional feature macro SEQ_DIV_DZ_EN: dz flag and a CALC-skipping divide-by-zero fast path.
module seq_div #(
   parameter int WIDTH = 8,
   parameter int CNTW  = $clog2(WIDTH) + 1
) (
   input  logic     clk,
   input  logic     rst,
   seq_div_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE   = 3'b001,
      CALC   = 3'b010,
      FINISH = 3'b100
   } state_t;

   state_t state_reg, state_next;

   logic signed [WIDTH-1:0] x_reg;
   logic                    xs_reg;
   logic                    ys_reg;
   logic        [WIDTH-1:0] dvd_reg;
   logic        [WIDTH-1:0] dvs_reg;
   logic        [WIDTH-1:0] rem_reg;
   logic        [CNTW-1:0]  cnt_reg;
   logic signed [WIDTH-1:0] q_reg;
   logic signed [WIDTH-1:0] r_reg;
   logic                    dz_reg;

   // Magnitudes at WIDTH+1 bits so the most negative operand stays exact.
   logic [WIDTH:0] abs_x;
   logic [WIDTH:0] abs_y;
   logic [WIDTH:0] rem_sh;
   logic [WIDTH:0] trial;
   logic [WIDTH:0] rem_new;
   logic           q_bit;
   logic [WIDTH-1:0] q_mag;
   logic [WIDTH-1:0] r_mag;
   logic [WIDTH-1:0] q_fin;
   logic [WIDTH-1:0] r_fin;
   logic             last_step;
   logic             y_zero_in;

   always_comb begin
      abs_x = bus.x[WIDTH-1] ? -{bus.x[WIDTH-1], bus.x} : {bus.x[WIDTH-1], bus.x};
      abs_y = bus.y[WIDTH-1] ? -{bus.y[WIDTH-1], bus.y} : {bus.y[WIDTH-1], bus.y};
      y_zero_in = (bus.y == '0);
   end

   // One restoring step on {rem, dividend}.
   always_comb begin
      rem_sh  = {rem_reg, dvd_reg[WIDTH-1]};
      trial   = rem_sh - {1'b0, dvs_reg};
      q_bit   = ~trial[WIDTH];
      rem_new = q_bit ? trial : rem_sh;
      q_mag   = {dvd_reg[WIDTH-2:0], q_bit};
      r_mag   = rem_new[WIDTH-1:0];
      last_step = (cnt_reg == CNTW'(WIDTH - 1));
      if (dvs_reg == '0) begin
         q_fin = '1;
         r_fin = x_reg;
      end else begin
         q_fin = (xs_reg ^ ys_reg) ? -q_mag : q_mag;
         r_fin = xs_reg ? -r_mag : r_mag;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (bus.start) begin
`ifdef SEQ_DIV_DZ_EN
               state_next = y_zero_in ? FINISH : CALC;
`else
               state_next = CALC;
`endif
            end
         end
         CALC:    if (last_step) state_next = FINISH;
         FINISH:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_reg   <= '0;
         xs_reg  <= 1'b0;
         ys_reg  <= 1'b0;
         dvd_reg <= '0;
         dvs_reg <= '0;
         rem_reg <= '0;
         cnt_reg <= '0;
         q_reg   <= '0;
         r_reg   <= '0;
         dz_reg  <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               // Operands track the inputs every IDLE edge; the start edge freezes them.
               x_reg   <= bus.x;
               xs_reg  <= bus.x[WIDTH-1];
               ys_reg  <= bus.y[WIDTH-1];
               dvd_reg <= abs_x[WIDTH-1:0];
               dvs_reg <= abs_y[WIDTH-1:0];
               rem_reg <= '0;
               cnt_reg <= '0;
`ifdef SEQ_DIV_DZ_EN
               if (bus.start && y_zero_in) begin
                  q_reg  <= '1;
                  r_reg  <= bus.x;
                  dz_reg <= 1'b1;
               end
`endif
            end
            CALC: begin
               dvd_reg <= q_mag;
               rem_reg <= r_mag;
               cnt_reg <= cnt_reg + 1'b1;
               if (last_step) begin
                  q_reg  <= q_fin;
                  r_reg  <= r_fin;
                  dz_reg <= (dvs_reg == '0);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.q     = q_reg;
   assign bus.r     = r_reg;
   assign bus.busy  = (state_reg != IDLE);
   assign bus.valid = (state_reg == FINISH);
`ifdef SEQ_DIV_DZ_EN
   assign bus.dz    = dz_reg;
`else
   // dz_reg only drives a port in the fast-path build; keep it visibly consumed.
   logic unused_dz;
   assign unused_dz = dz_reg;
`endif

endmodule

// File: tb/tb_seq_div.sv
// Directed self-checking bench for seq_div at WIDTH=8, with hand-computed expectations.
// Works in both builds (SEQ_DIV_DZ_EN defined or not).
module tb_seq_div;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

`ifdef SEQ_DIV_DZ_EN
   localparam bit DZ_BUILD = 1'b1;
`else
   localparam bit DZ_BUILD = 1'b0;
`endif

   seq_div_if #(.WIDTH(8)) bus ();

   seq_div #(.WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end else begin
         $display("ok   %s = %0d", tag, got);
      end
   endtask

   // Called right after the edge that sampled start; latency counts edges
   // from that edge to the first edge that sees valid high.
   task automatic wait_result(input string tag, input int eq, input int er, input bit edz);
      int lat;
      int elat;
      lat  = -1;
      elat = (edz && DZ_BUILD) ? 1 : 9;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (bus.valid === 1'b1) begin
            lat = i + 1;
            break;
         end
      end
      check({tag, "_lat"}, lat, elat);
      check({tag, "_q"}, $signed(bus.q), eq);
      check({tag, "_r"}, $signed(bus.r), er);
`ifdef SEQ_DIV_DZ_EN
      check({tag, "_dz"}, {31'd0, bus.dz}, {31'd0, edz});
`endif
      @(negedge clk);
      check({tag, "_pulse"}, {31'd0, bus.valid}, 0);
   endtask

   task automatic run_div(input string tag, input logic signed [7:0] a, input logic signed [7:0] b,
                          input int eq, input int er, input bit edz);
      @(negedge clk);
      bus.x     = a;
      bus.y     = b;
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      wait_result(tag, eq, er, edz);
   endtask

   initial begin
      int pulses;
      checks    = 0;
      failures  = 0;
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.x     = 8'sd0;
      bus.y     = 8'sd0;
      repeat (2) @(negedge clk);
      check("rst_busy", {31'd0, bus.busy}, 0);
      check("rst_valid", {31'd0, bus.valid}, 0);
      check("rst_q", $signed(bus.q), 0);
      check("rst_r", $signed(bus.r), 0);
`ifdef SEQ_DIV_DZ_EN
      check("rst_dz", {31'd0, bus.dz}, 0);
`endif
      rst = 1'b0;

      run_div("d100_7",   8'sd100,  8'sd7,    14,   2,   1'b0);
      run_div("dm100_7",  -8'sd100, 8'sd7,    -14,  -2,  1'b0);
      run_div("d100_m7",  8'sd100,  -8'sd7,   -14,  2,   1'b0);
      run_div("dm100_m7", -8'sd100, -8'sd7,   14,   -2,  1'b0);
      run_div("dm128_m1", -8'sd128, -8'sd1,   -128, 0,   1'b0);
      run_div("dm128_1",  -8'sd128, 8'sd1,    -128, 0,   1'b0);
      run_div("d127_m128", 8'sd127, -8'sd128, 0,    127, 1'b0);
      run_div("d7_100",   8'sd7,    8'sd100,  0,    7,   1'b0);
      run_div("d5_0",     8'sd5,    8'sd0,    -1,   5,   1'b1);
      run_div("dm5_0",    -8'sd5,   8'sd0,    -1,   -5,  1'b1);

      // start held high with operands changing mid-division.
      @(negedge clk);
      bus.x     = 8'sd100;
      bus.y     = 8'sd7;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.x = 8'sd50;
      bus.y = 8'sd3;
      check("hold_busy", {31'd0, bus.busy}, 1);
      wait_result("hold1", 14, 2, 1'b0);
      check("hold_idle", {31'd0, bus.busy}, 0);
      @(posedge clk);
      #1 bus.start = 1'b0;
      check("hold_restart", {31'd0, bus.busy}, 1);
      wait_result("hold2", 16, 2, 1'b0);

      // Reset during the 4th CALC cycle aborts the division.
      @(negedge clk);
      bus.x     = 8'sd100;
      bus.y     = 8'sd7;
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_busy", {31'd0, bus.busy}, 0);
      check("abort_valid", {31'd0, bus.valid}, 0);
      check("abort_q", $signed(bus.q), 0);
      check("abort_r", $signed(bus.r), 0);
      @(negedge clk);
      rst    = 1'b0;
      pulses = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (bus.valid === 1'b1) pulses++;
      end
      check("abort_novalid", pulses, 0);
      check("abort_idle", {31'd0, bus.busy}, 0);
      run_div("d20_3", 8'sd20, 8'sd3, 6, 2, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
